// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: holds HI/LO, models fixed MULT/DIV latency and drives busy/stall.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MDU_MADD_EN is defined.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        flush,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   // state  | meaning
   // S_IDLE | ready to accept; MTHI/MTLO complete here in one edge
   // S_MUL  | multiply-class op counting down, writes HI/LO on 1->0
   // S_DIV  | divide-class op counting down, writes HI/LO on 1->0 unless divisor is zero
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic is_mul, is_div, sgn;
   logic [63:0] a_ext, b_ext, prod, mul_res;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

`ifdef MDU_MADD_EN
   assign is_mul = (op == 4'd1) || (op == 4'd2) || ((op >= 4'd7) && (op <= 4'd10));
`else
   assign is_mul = (op == 4'd1) || (op == 4'd2);
`endif
   assign is_div = (op == 4'd3) || (op == 4'd4);

   assign busy      = (state_q != S_IDLE);
   assign stall_req = busy | (start & (is_mul | is_div) & ~flush);
   assign hi        = hi_q;
   assign lo        = lo_q;

   // Datapath works on latched operands only; results are consumed on the final count edge.
   always_comb begin
      sgn     = (op_q == 4'd1) || (op_q == 4'd3) || (op_q == 4'd7) || (op_q == 4'd9);
      a_ext   = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
      b_ext   = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
      prod    = a_ext * b_ext;
      mul_res = prod;
`ifdef MDU_MADD_EN
      if ((op_q == 4'd7) || (op_q == 4'd8))
         mul_res = {hi_q, lo_q} + prod;
      else if ((op_q == 4'd9) || (op_q == 4'd10))
         mul_res = {hi_q, lo_q} - prod;
`endif
      // Magnitude divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
      a_mag  = (sgn && a_q[31]) ? -a_q : a_q;
      b_mag  = (sgn && b_q[31]) ? -b_q : b_q;
      b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      quo    = (sgn && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
      rem    = (sgn && a_q[31]) ? -r_mag : r_mag;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               if (is_mul) begin
                  state_d = S_MUL;
                  cnt_d   = CW'(MULT_CYCLES);
                  op_d    = op;
                  a_d     = rs;
                  b_d     = rt;
               end else if (is_div) begin
                  state_d = S_DIV;
                  cnt_d   = CW'(DIV_CYCLES);
                  op_d    = op;
                  a_d     = rs;
                  b_d     = rt;
               end else if (op == 4'd5) begin
                  hi_d = rs;
               end else if (op == 4'd6) begin
                  lo_d = rs;
               end
            end
         end
         S_MUL: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d      = S_IDLE;
               {hi_d, lo_d} = mul_res;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of back-to-back ops plus hand sequences for busy-start, flush and reset.
module tb_mdu_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [3:0]  op;
   logic [31:0] rs, rt;
   logic        busy, stall_req;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
      .flush(flush), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          ncyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where busy is first seen low.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_stall, input string nm, output int n);
      int sbad;
      start = 1'b1; op = o; rs = a; rt = b;
      #1;
      chk({nm, "_stall_start"}, 64'(stall_req), 64'(exp_stall));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 4'd0; rs = 32'hDEADBEEF; rt = 32'h0BADF00D;
      n = 0; sbad = 0;
      while (busy && n < 200) begin
         if (!stall_req) sbad++;
         n++;
         @(negedge clk);
      end
      chk({nm, "_stall_busy"}, 64'(sbad), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; rs = '0; rt = '0;

      vt.push_back('{4'd1,  32'hFFFFFFFE, 32'd3,       5,  32'hFFFFFFFF, 32'hFFFFFFFA});
      vt.push_back('{4'd2,  32'hFFFFFFFE, 32'd3,       5,  32'h00000002, 32'hFFFFFFFA});
      vt.push_back('{4'd1,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000});
      vt.push_back('{4'd3,  32'hFFFFFFF9, 32'd2,       10, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vt.push_back('{4'd4,  32'hFFFFFFF9, 32'd2,       10, 32'h00000001, 32'h7FFFFFFC});
      vt.push_back('{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000});
      vt.push_back('{4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
      vt.push_back('{4'd5,  32'h12345678, 32'd0,       0,  32'h12345678, 32'hFFFFFFFD});
      vt.push_back('{4'd4,  32'd5,        32'd0,       10, 32'h12345678, 32'hFFFFFFFD});
      vt.push_back('{4'd6,  32'hFFFFFFFF, 32'd9,       0,  32'h12345678, 32'hFFFFFFFF});
      vt.push_back('{4'd5,  32'h00000000, 32'd9,       0,  32'h00000000, 32'hFFFFFFFF});
      vt.push_back('{4'd0,  32'h11111111, 32'd3,       0,  32'h00000000, 32'hFFFFFFFF});
      vt.push_back('{4'd15, 32'h22222222, 32'd3,       0,  32'h00000000, 32'hFFFFFFFF});
`ifdef MDU_MADD_EN
      vt.push_back('{4'd8,  32'd1,        32'd1,       5,  32'h00000001, 32'h00000000});
      vt.push_back('{4'd9,  32'd2,        32'd3,       5,  32'h00000000, 32'hFFFFFFFA});
`else
      vt.push_back('{4'd8,  32'd1,        32'd1,       0,  32'h00000000, 32'hFFFFFFFF});
      vt.push_back('{4'd9,  32'd2,        32'd3,       0,  32'h00000000, 32'hFFFFFFFF});
`endif

      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         issue(vt[i].op, vt[i].rs, vt[i].rt, vt[i].ncyc != 0, $sformatf("v%0d", i), n);
         chk($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vt[i].ncyc));
         chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vt[i].hi));
         chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vt[i].lo));
      end

      // Start arriving mid-operation is dropped and never queued.
      start = 1'b1; op = 4'd1; rs = 32'd2; rt = 32'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         if (n == 1) begin
            start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
         end else begin
            start = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start_cycles", 64'(n), 64'd5);
      chk("busy_start_hilo", {hi, lo}, {32'd0, 32'd6});
      @(negedge clk);
      chk("busy_start_not_queued", 64'(busy), 64'd0);

      // Flush blocks acceptance in its own cycle.
      start = 1'b1; flush = 1'b1; op = 4'd1; rs = 32'd7; rt = 32'd7;
      #1;
      chk("flush_stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hilo", {hi, lo}, {32'd0, 32'd6});

      // Flush arriving after acceptance does not cancel the op.
      start = 1'b1; op = 4'd1; rs = 32'd3; rt = 32'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      flush = 1'b0;
      chk("flight_flush_cycles", 64'(n), 64'd5);
      chk("flight_flush_hilo", {hi, lo}, {32'd0, 32'd12});

      // Asynchronous reset in the third busy cycle of a DIV.
      start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("post_reset_idle", {31'd0, busy, hi, lo[30:0]}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
